sensor_debouncer: RTL and testbench

SENSOR_DEBOUNCER -- requirements
Module: sensor_debouncer

---
 rtl/sensor_debouncer.sv | 191 +++++++++++++++++++
 tb/tb_sensor_debouncer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sensor_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : sensor_debouncer
// Description : Two-channel debouncer for the gate sensors A and B. Each raw
//               input is synchronized, then filtered by a four-state FSM that
//               accepts a new level only after DEBOUNCE_CYCLES consecutive
//               synchronized samples. Provides registered levels, one-cycle
//               edge pulses and a saturating count of rejected glitches.
// Revision    : 1.0 - initial release
// ============================================================================
module sensor_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500,
  parameter int unsigned CNT_W           = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       botonA_raw,
  input  logic       botonB_raw,
  output logic       botonA,
  output logic       botonB,
  output logic       a_rise,
  output logic       a_fall,
  output logic       b_rise,
  output logic       b_fall,
  output logic [7:0] glitch_count
);

  localparam logic [1:0] ST_STABLE0 = 2'd0;
  localparam logic [1:0] ST_PEND1   = 2'd1;
  localparam logic [1:0] ST_STABLE1 = 2'd2;
  localparam logic [1:0] ST_PEND0   = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Channel 0 is sensor A, channel 1 is sensor B.
  logic [1:0] raw_w;
  logic [1:0] level_w;
  logic [1:0] rise_w;
  logic [1:0] fall_w;
  logic [1:0] reject_w;

  assign raw_w = {botonB_raw, botonA_raw};

  generate
    for (genvar ch = 0; ch < 2; ch++) begin : g_chan
      logic             sync1_q;
      logic             sync2_q;
      logic [1:0]       state_q;
      logic [1:0]       state_d;
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;
      logic             level_q;
      logic             level_d;
      logic             rise_q;
      logic             rise_d;
      logic             fall_q;
      logic             fall_d;
      logic             reject_d;

      // Two-stage synchronizer for the asynchronous raw sensor input.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          sync1_q <= 1'b0;
          sync2_q <= 1'b0;
        end else begin
          sync1_q <= raw_w[ch];
          sync2_q <= sync1_q;
        end
      end

      // FSM state and debounce counter registers.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          state_q <= ST_STABLE0;
          cnt_q   <= '0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
        end
      end

      // Next state: a pending level is dropped on the first contrary sample
      // and accepted once the counter has seen DEBOUNCE_CYCLES samples.
      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
          ST_STABLE0: begin
            if (sync2_q) begin
              state_d = ST_PEND1;
              cnt_d   = CNT_ONE;
            end else begin
              cnt_d   = '0;
            end
          end
          ST_PEND1: begin
            if (!sync2_q) begin
              state_d = ST_STABLE0;
              cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
              state_d = ST_STABLE1;
              cnt_d   = '0;
            end else begin
              cnt_d   = cnt_q + CNT_ONE;
            end
          end
          ST_STABLE1: begin
            if (!sync2_q) begin
              state_d = ST_PEND0;
              cnt_d   = CNT_ONE;
            end else begin
              cnt_d   = '0;
            end
          end
          ST_PEND0: begin
            if (sync2_q) begin
              state_d = ST_STABLE1;
              cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
              state_d = ST_STABLE0;
              cnt_d   = '0;
            end else begin
              cnt_d   = cnt_q + CNT_ONE;
            end
          end
          default: begin
            state_d = ST_STABLE0;
            cnt_d   = '0;
          end
        endcase
      end

      // Output decode from the transition being taken this cycle.
      always_comb begin
        level_d  = (state_d == ST_STABLE1) || (state_d == ST_PEND0);
        rise_d   = (state_q == ST_PEND1) && (state_d == ST_STABLE1);
        fall_d   = (state_q == ST_PEND0) && (state_d == ST_STABLE0);
        reject_d = ((state_q == ST_PEND1) && (state_d == ST_STABLE0)) ||
                   ((state_q == ST_PEND0) && (state_d == ST_STABLE1));
      end

      // Register level and pulses so they change together on acceptance.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          level_q <= 1'b0;
          rise_q  <= 1'b0;
          fall_q  <= 1'b0;
        end else begin
          level_q <= level_d;
          rise_q  <= rise_d;
          fall_q  <= fall_d;
        end
      end

      assign level_w[ch]  = level_q;
      assign rise_w[ch]   = rise_q;
      assign fall_w[ch]   = fall_q;
      assign reject_w[ch] = reject_d;
    end
  endgenerate

  logic [7:0] glitch_q;
  logic [7:0] glitch_d;
  logic [8:0] glitch_sum_w;

  // Add this cycle's rejections from both channels, clamping at 255.
  always_comb begin
    glitch_sum_w = {1'b0, glitch_q} + {8'd0, reject_w[0]} + {8'd0, reject_w[1]};
    glitch_d     = glitch_sum_w[8] ? 8'hFF : glitch_sum_w[7:0];
  end

  // Rejection counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      glitch_q <= 8'd0;
    end else begin
      glitch_q <= glitch_d;
    end
  end

  assign botonA       = level_w[0];
  assign botonB       = level_w[1];
  assign a_rise       = rise_w[0];
  assign a_fall       = fall_w[0];
  assign b_rise       = rise_w[1];
  assign b_fall       = fall_w[1];
  assign glitch_count = glitch_q;

endmodule
`default_nettype wire

// File: tb/tb_sensor_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sensor_debouncer
// Description : Self-checking bench for sensor_debouncer with a run-length
//               reference model of the debounce rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sensor_debouncer;

  localparam int DC = 500;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       botonA_raw = 1'b0;
  logic       botonB_raw = 1'b0;
  logic       botonA, botonB, a_rise, a_fall, b_rise, b_fall;
  logic [7:0] glitch_count;

  int tests = 0;
  int fails = 0;

  // Reference model: per channel a 2-deep sample delay, the accepted level
  // and the length of the current run of samples disagreeing with it.
  int m_p1[2], m_p2[2], m_lvl[2], m_run[2], m_rise[2], m_fall[2];
  int m_glitch;

  sensor_debouncer #(.DEBOUNCE_CYCLES(DC), .CNT_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .botonA_raw   (botonA_raw),
    .botonB_raw   (botonB_raw),
    .botonA       (botonA),
    .botonB       (botonB),
    .a_rise       (a_rise),
    .a_fall       (a_fall),
    .b_rise       (b_rise),
    .b_fall       (b_fall),
    .glitch_count (glitch_count)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < 2; c++) begin
      m_p1[c] = 0; m_p2[c] = 0; m_lvl[c] = 0; m_run[c] = 0;
      m_rise[c] = 0; m_fall[c] = 0;
    end
    m_glitch = 0;
  endtask

  task automatic model_edge();
    int rej;
    int s;
    int raw[2];
    if (!reset) begin
      model_clear();
      return;
    end
    raw[0] = int'(botonA_raw);
    raw[1] = int'(botonB_raw);
    rej = 0;
    for (int c = 0; c < 2; c++) begin
      s = m_p2[c];
      m_p2[c] = m_p1[c];
      m_p1[c] = raw[c];
      m_rise[c] = 0;
      m_fall[c] = 0;
      if (s != m_lvl[c]) begin
        m_run[c]++;
        if (m_run[c] == DC) begin
          m_lvl[c] = s;
          if (s == 1) m_rise[c] = 1; else m_fall[c] = 1;
          m_run[c] = 0;
        end
      end else begin
        if (m_run[c] > 0) rej++;
        m_run[c] = 0;
      end
    end
    m_glitch = (m_glitch + rej > 255) ? 255 : m_glitch + rej;
  endtask

  task automatic check_all(input string tag);
    int obs;
    int exp;
    obs = {botonA, botonB, a_rise, a_fall, b_rise, b_fall, glitch_count};
    exp = (m_lvl[0] << 13) | (m_lvl[1] << 12) | (m_rise[0] << 11) |
          (m_fall[0] << 10) | (m_rise[1] << 9) | (m_fall[1] << 8) | m_glitch;
    chk(tag, obs, exp);
  endtask

  task automatic step(input int n, input string tag);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all(tag);
    end
  endtask

  initial begin
    int n;
    int g0;
    int delta;

    // Reset held with A raw high: everything stays zero.
    model_clear();
    reset = 1'b0;
    botonA_raw = 1'b1;
    step(5, "reset_hold");
    chk("reset_outputs", {botonA, botonB, a_rise, a_fall, b_rise, b_fall, glitch_count}, 0);

    // Release: A accepted 501 edges after the first sampling edge.
    reset = 1'b1;
    n = 0;
    for (int i = 1; i <= 2000; i++) begin
      step(1, "post_reset_accept");
      if (a_rise === 1'b1) begin
        n = i;
        break;
      end
    end
    chk("a_rise_latency_edges", n, 502);
    chk("botonA_after_accept", int'(botonA), 1);
    botonA_raw = 1'b0;
    step(600, "a_fall_accept");
    chk("botonA_after_fall", int'(botonA), 0);

    // 200-cycle pulse is rejected once.
    botonA_raw = 1'b1;
    step(200, "short_pulse");
    botonA_raw = 1'b0;
    step(300, "short_pulse_end");
    chk("glitch_after_short", int'(glitch_count), 1);
    chk("botonA_after_short", int'(botonA), 0);

    // Entry pattern then exit pattern, 1000 cycles apart.
    botonA_raw = 1'b1; step(1000, "entry_a_on");
    botonB_raw = 1'b1; step(1000, "entry_b_on");
    botonA_raw = 1'b0; step(1000, "entry_a_off");
    botonB_raw = 1'b0; step(1000, "entry_b_off");
    botonB_raw = 1'b1; step(1000, "exit_b_on");
    botonA_raw = 1'b1; step(1000, "exit_a_on");
    botonB_raw = 1'b0; step(1000, "exit_b_off");
    botonA_raw = 1'b0; step(1000, "exit_a_off");
    chk("levels_after_patterns", int'({botonA, botonB}), 0);

    // Simultaneous 100-cycle glitches on both channels.
    g0 = int'(glitch_count);
    botonA_raw = 1'b1;
    botonB_raw = 1'b1;
    step(100, "dual_glitch");
    botonA_raw = 1'b0;
    botonB_raw = 1'b0;
    delta = 0;
    for (int i = 0; i < 10; i++) begin
      step(1, "dual_glitch_end");
      if (int'(glitch_count) != g0) begin
        delta = int'(glitch_count) - g0;
        break;
      end
    end
    chk("dual_glitch_delta", delta, 2);

    // Randomized segments on both channels against the model.
    repeat (40) begin
      botonA_raw = 1'($urandom_range(0, 1));
      botonB_raw = 1'($urandom_range(0, 1));
      step($urandom_range(20, 700), "random");
    end
    botonA_raw = 1'b0;
    botonB_raw = 1'b0;
    step(600, "random_settle");

    // 300 short glitches on A drive the counter to saturation.
    repeat (300) begin
      botonA_raw = 1'b1; step(50, "sat_hi");
      botonA_raw = 1'b0; step(50, "sat_lo");
    end
    chk("glitch_saturated", int'(glitch_count), 255);
    chk("botonA_after_sat", int'(botonA), 0);

    // Reset mid-pending: cleared immediately, no pulse, no rejection.
    reset = 1'b0;
    model_clear();
    step(3, "pend_reset_prep");
    reset = 1'b1;
    botonA_raw = 1'b1;
    step(302, "pend_count");
    reset = 1'b0;
    model_clear();
    #1;
    chk("reset_mid_pend_immediate",
        int'({botonA, botonB, a_rise, a_fall, b_rise, b_fall, glitch_count}), 0);
    botonA_raw = 1'b0;
    step(5, "pend_reset_hold");
    reset = 1'b1;
    step(600, "pend_reset_after");
    chk("glitch_after_pend_reset", int'(glitch_count), 0);
    chk("botonA_after_pend_reset", int'(botonA), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
